// File: rtl/signed_divider_pkg.sv
// Shared constants, state encoding and two's-complement helpers for the
// iterative signed divider.
package divider_pkg;

    localparam int DIV_W    = 8;
    localparam int DIV_ITER = DIV_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic logic [DIV_W-1:0] twos_neg(input logic [DIV_W-1:0] x);
        return ~x + {{(DIV_W-1){1'b0}}, 1'b1};
    endfunction

    // |-128| wraps to 0x80, which reads correctly as an unsigned magnitude
    function automatic logic [DIV_W-1:0] twos_mag(input logic [DIV_W-1:0] x);
        return x[DIV_W-1] ? twos_neg(x) : x;
    endfunction

endpackage

// File: rtl/signed_divider_if.sv
// Request/result bundle between the processor top level and the divider.
interface signed_divider_if;
    import divider_pkg::*;

    logic             Start;
    logic [DIV_W-1:0] Dividend;
    logic [DIV_W-1:0] Divisor;
    logic [DIV_W-1:0] Quotient;
    logic [DIV_W-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic             Ovf;

    modport master (
        output Start, Dividend, Divisor,
        input  Quotient, Remainder, Busy, Done, DivZero, Ovf
    );

    modport slave (
        input  Start, Dividend, Divisor,
        output Quotient, Remainder, Busy, Done, DivZero, Ovf
    );
endinterface

// File: rtl/signed_divider_control.sv
// Divider sequencer: IDLE/CALC/FIX/DONE state machine with the 3-bit step
// counter, producing datapath strobes and registered Busy/Done.
module divider_control
    import divider_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    input  logic div_zero,
    output logic load,
    output logic step,
    output logic fix,
    output logic busy,
    output logic done
);

    div_state_t state_r;
    logic [2:0] count_r;
    logic       busy_r;
    logic       done_r;

    assign load = (state_r == IDLE) && start;
    assign step = (state_r == CALC);
    assign fix  = (state_r == FIX);
    assign busy = busy_r;
    assign done = done_r;

    // State machine, iteration counter and registered status flags
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            count_r <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        count_r <= 3'd0;
                        if (div_zero) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= CALC;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    count_r <= count_r + 3'd1;
                    if (count_r == 3'(DIV_ITER - 1)) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    state_r <= DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                DONE: begin
                    // a held Start must not retrigger, so wait for release
                    if (!start) begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= 3'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/signed_divider.sv
// 8-bit signed restoring divider: magnitude conversion, R/Q shift registers,
// 9-bit trial subtraction and sign fix-up, sequenced by divider_control.
module signed_divider
    import divider_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    signed_divider_if.slave  div
);

    logic             load_s, step_s, fix_s, busy_s, done_s, div_zero_s;
    logic [DIV_W:0]   r_r;
    logic [DIV_W-1:0] q_r;
    logic [DIV_W-1:0] dvs_mag_r;
    logic             neg_q_r, neg_r_r, ovf_case_r;
    logic [DIV_W-1:0] quotient_r, remainder_r;
    logic             div_zero_r, ovf_r;
    logic [DIV_W+1:0] shifted_s;
    logic [DIV_W+1:0] trial_s;

    assign div_zero_s = (div.Divisor == {DIV_W{1'b0}});

    divider_control u_ctrl (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (div.Start),
        .div_zero (div_zero_s),
        .load     (load_s),
        .step     (step_s),
        .fix      (fix_s),
        .busy     (busy_s),
        .done     (done_s)
    );

    // Extra top bit makes trial_s[DIV_W+1] a clean borrow/sign indicator
    assign shifted_s = {r_r, q_r[DIV_W-1]};
    assign trial_s   = shifted_s - {2'b00, dvs_mag_r};

    // Operand capture, restoring steps and final sign correction
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_r         <= {(DIV_W+1){1'b0}};
            q_r         <= {DIV_W{1'b0}};
            dvs_mag_r   <= {DIV_W{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            ovf_case_r  <= 1'b0;
            quotient_r  <= {DIV_W{1'b0}};
            remainder_r <= {DIV_W{1'b0}};
            div_zero_r  <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (load_s) begin
            ovf_r <= 1'b0;
            if (div_zero_s) begin
                quotient_r  <= {DIV_W{1'b1}};
                remainder_r <= div.Dividend;
                div_zero_r  <= 1'b1;
            end else begin
                r_r         <= {(DIV_W+1){1'b0}};
                q_r         <= twos_mag(div.Dividend);
                dvs_mag_r   <= twos_mag(div.Divisor);
                neg_q_r     <= div.Dividend[DIV_W-1] ^ div.Divisor[DIV_W-1];
                neg_r_r     <= div.Dividend[DIV_W-1];
                ovf_case_r  <= (div.Dividend == 8'h80) && (div.Divisor == 8'hFF);
                quotient_r  <= {DIV_W{1'b0}};
                remainder_r <= {DIV_W{1'b0}};
                div_zero_r  <= 1'b0;
            end
        end else if (step_s) begin
            r_r <= trial_s[DIV_W+1] ? shifted_s[DIV_W:0] : trial_s[DIV_W:0];
            q_r <= {q_r[DIV_W-2:0], ~trial_s[DIV_W+1]};
        end else if (fix_s) begin
            ovf_r <= ovf_case_r;
            if (ovf_case_r) begin
                quotient_r  <= 8'h80;
                remainder_r <= 8'h00;
            end else begin
                quotient_r  <= neg_q_r ? twos_neg(q_r) : q_r;
                remainder_r <= neg_r_r ? twos_neg(r_r[DIV_W-1:0]) : r_r[DIV_W-1:0];
            end
        end else begin
            quotient_r <= quotient_r;
        end
    end

    assign div.Quotient  = quotient_r;
    assign div.Remainder = remainder_r;
    assign div.Busy      = busy_s;
    assign div.Done      = done_s;
    assign div.DivZero   = div_zero_r;
    assign div.Ovf       = ovf_r;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: directed cases, random operands
// against an integer-arithmetic reference, held Start and mid-run reset.
module tb_signed_divider;
    import divider_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    signed_divider_if dif ();

    signed_divider dut (
        .Clk   (Clk),
        .Reset (Reset),
        .div   (dif)
    );

    always #5 Clk = ~Clk;

    // Reference: C-style truncating division on plain integers
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int ia, ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (ib == 0) begin
            q = 8'hFF; r = a; dz = 1'b1;
        end else if (ia == -128 && ib == -1) begin
            q = 8'h80; r = 8'h00; ov = 1'b1;
        end else begin
            q = 8'(ia / ib);
            r = 8'(ia % ib);
        end
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eov, input string tag);
        int   cyc;
        int   exp_lat;
        logic busy_k, busy_seen, overlap;
        @(negedge Clk);
        dif.Start = 1'b1; dif.Dividend = a; dif.Divisor = b;
        @(posedge Clk); #1;
        busy_k = dif.Busy; busy_seen = dif.Busy; overlap = dif.Busy & dif.Done;
        cyc = 0;
        dif.Dividend = ~a;
        dif.Divisor  = b ^ 8'h5A;
        while (dif.Done !== 1'b1 && cyc < 20) begin
            @(posedge Clk); #1;
            cyc++;
            busy_seen = busy_seen | dif.Busy;
            overlap   = overlap | (dif.Busy & dif.Done);
        end
        exp_lat = edz ? 0 : 9;
        checks++; if (cyc !== exp_lat) begin failures++;
            $display("FAIL %s latency: got %0d edges, want %0d", tag, cyc, exp_lat); end
        checks++; if (busy_k !== ~edz) begin failures++;
            $display("FAIL %s busy_at_accept: got %b, want %b", tag, busy_k, ~edz); end
        checks++; if (busy_seen !== ~edz) begin failures++;
            $display("FAIL %s busy_seen: got %b, want %b", tag, busy_seen, ~edz); end
        checks++; if (overlap !== 1'b0) begin failures++;
            $display("FAIL %s busy_done_overlap: got %b, want 0", tag, overlap); end
        checks++; if (dif.Quotient !== eq) begin failures++;
            $display("FAIL %s quotient (%h/%h): got %h, want %h", tag, a, b, dif.Quotient, eq); end
        checks++; if (dif.Remainder !== er) begin failures++;
            $display("FAIL %s remainder (%h/%h): got %h, want %h", tag, a, b, dif.Remainder, er); end
        checks++; if (dif.DivZero !== edz || dif.Ovf !== eov) begin failures++;
            $display("FAIL %s flags dz/ovf: got %b%b, want %b%b", tag, dif.DivZero, dif.Ovf, edz, eov); end
        @(negedge Clk);
        dif.Start = 1'b0;
        @(posedge Clk); #1;
        checks++; if (dif.Done !== 1'b0 || dif.Quotient !== eq || dif.Remainder !== er) begin failures++;
            $display("FAIL %s release: got done=%b q=%h r=%h, want done=0 q=%h r=%h",
                     tag, dif.Done, dif.Quotient, dif.Remainder, eq, er); end
    endtask

    task automatic run_model_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] q, r;
        logic dz, ov;
        model(a, b, q, r, dz, ov);
        run_op(a, b, q, r, dz, ov, tag);
    endtask

    task automatic test_reset();
        checks++;
        if ({dif.Quotient, dif.Remainder, dif.Busy, dif.Done, dif.DivZero, dif.Ovf} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs: got q=%h r=%h b=%b d=%b z=%b o=%b, want all 0",
                     dif.Quotient, dif.Remainder, dif.Busy, dif.Done, dif.DivZero, dif.Ovf);
        end
    endtask

    task automatic test_directed();
        run_op(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, "pos_pos");
        run_op(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, "neg_pos");
        run_op(8'h05, 8'hEC, 8'h00, 8'h05, 1'b0, 1'b0, "small_div");
        run_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, "ovf");
        run_op(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, "min_by_one");
        run_op(8'h35, 8'h00, 8'hFF, 8'h35, 1'b1, 1'b0, "div_zero");
        run_op(8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, "max_by_min");
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        for (int i = 0; i < 150; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 7))
                0: b = 8'h00;
                1: b = 8'hFF;
                2: a = 8'h80;
                default: b = b;
            endcase
            run_model_op(a, b, "random");
        end
    endtask

    task automatic test_hold_start();
        int   accepts;
        logic prev_busy;
        accepts = 0;
        prev_busy = 1'b0;
        @(negedge Clk);
        dif.Start = 1'b1; dif.Dividend = 8'h64; dif.Divisor = 8'h07;
        for (int i = 0; i < 30; i++) begin
            @(posedge Clk); #1;
            if (dif.Busy === 1'b1 && prev_busy === 1'b0) accepts++;
            prev_busy = dif.Busy;
            if (i == 15) begin dif.Dividend = 8'h05; dif.Divisor = 8'h03; end
        end
        checks++; if (accepts !== 1) begin failures++;
            $display("FAIL hold_accepts: got %0d, want 1", accepts); end
        checks++; if (dif.Done !== 1'b1 || dif.Quotient !== 8'h0E || dif.Remainder !== 8'h02) begin failures++;
            $display("FAIL hold_result: got done=%b q=%h r=%h, want done=1 q=0e r=02",
                     dif.Done, dif.Quotient, dif.Remainder); end
        @(negedge Clk);
        dif.Start = 1'b0;
        @(posedge Clk); #1;
        checks++; if (dif.Done !== 1'b0 || dif.Quotient !== 8'h0E || dif.Remainder !== 8'h02) begin failures++;
            $display("FAIL hold_release: got done=%b q=%h r=%h, want done=0 q=0e r=02",
                     dif.Done, dif.Quotient, dif.Remainder); end
        run_op(8'h05, 8'h03, 8'h01, 8'h02, 1'b0, 1'b0, "after_hold");
    endtask

    task automatic test_reset_mid();
        @(negedge Clk);
        dif.Start = 1'b1; dif.Dividend = 8'h9C; dif.Divisor = 8'h07;
        @(posedge Clk);
        @(negedge Clk);
        dif.Start = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({dif.Quotient, dif.Remainder, dif.Busy, dif.Done, dif.DivZero, dif.Ovf} !== 20'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got q=%h r=%h b=%b d=%b, want all 0",
                     dif.Quotient, dif.Remainder, dif.Busy, dif.Done);
        end
        checks++; if (dut.u_ctrl.state_r !== IDLE) begin failures++;
            $display("FAIL reset_mid_state: got %0d, want IDLE", dut.u_ctrl.state_r); end
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (dif.Busy !== 1'b0 || dif.Done !== 1'b0) begin failures++;
            $display("FAIL reset_mid_idle: got busy=%b done=%b, want 0 0", dif.Busy, dif.Done); end
        run_op(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_model_op(8'($urandom), 8'($urandom_range(1, 255)), "back_to_back");
        end
    endtask

    initial begin
        Reset = 1'b0;
        dif.Start = 1'b0; dif.Dividend = 8'h00; dif.Divisor = 8'h00;
        #12;
        test_reset();
        @(negedge Clk);
        Reset = 1'b1;
        test_directed();
        test_random();
        test_hold_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_divider.md
# signed_divider

Iterative 8-bit signed restoring divider: the inverse companion of the shift-add multiplier datapath. It accepts a synchronized dividend and divisor and produces quotient and remainder one bit per clock. It sits beside the multiplier under the processor top level, which drives it from the switch and button synchronizers and shows the results on the hex drivers.

## Interface
- Parameters: none. The width is fixed at 8 by package constant `DIV_W`.
- `Clk` input, 1 bit: system clock; all state changes on the rising edge.
- `Reset` input, 1 bit: asynchronous, active-low reset. Asserting it clears every register and output at once.
- `Start` input, 1 bit: synchronized active-high request, level-sensitive. One operation runs per assertion.
- `Dividend` input, 8 bits: two's-complement dividend, sampled on the accepting edge only.
- `Divisor` input, 8 bits: two's-complement divisor, sampled on the accepting edge only.
- `Quotient` output, 8 bits: two's-complement quotient, truncated toward zero.
- `Remainder` output, 8 bits: two's-complement remainder; its sign follows the dividend.
- `Busy` output, 1 bit: high while in `CALC` or `FIX`.
- `Done` output, 1 bit: high in `DONE`; the results are valid while it is high.
- `DivZero` output, 1 bit: last operation had divisor 0.
- `Ovf` output, 1 bit: last operation was -128 / -1.

## Operation
- Reset value of all outputs: 0. FSM state after reset: `IDLE`.
- **IDLE**, with `Start` high:
  - Latch the magnitudes |Dividend| and |Divisor| as unsigned 8-bit values (|-128| = 0x80).
  - Latch `NegQ` = sign(Dividend) XOR sign(Divisor), and `NegR` = sign(Dividend).
  - Clear `DivZero`, `Ovf`, the quotient and the partial remainder. Set count = 0. Go to `CALC`.
- **IDLE**, divide-by-zero case (Divisor = 0): skip `CALC`. Set `Quotient` = 0xFF, `Remainder` = Dividend, `DivZero` = 1. Go directly to `DONE`.
- **CALC**, one restoring step per cycle:
  - Shift {R, Q} left by one; the partial remainder R is 9 bits.
  - trial = R - {0, |Divisor|}.
  - If trial ≥ 0: R = trial and Q[0] = 1. Otherwise keep R and set Q[0] = 0.
  - Increment count. After the step with count = 7, go to `FIX`.
- **FIX**:
  - `Quotient` = NegQ ? -Q : Q.
  - `Remainder` = NegR ? -R[7:0] : R[7:0].
  - `Ovf` = 1 if and only if the operands were 0x80 and 0xFF. In that case `Quotient` = 0x80 and `Remainder` = 0.
  - Go to `DONE`.
- **DONE**:
  - Hold `Quotient`, `Remainder` and the flags. Stay while `Start` is high; a held button yields exactly one operation.
  - When `Start` goes low, go to `IDLE`. `Done` drops; the result outputs keep their values until the next acceptance.
- Arithmetic is modulo 2^8 on the outputs and 9-bit internally. No saturation beyond the `Ovf` case.
- `Start` and operand changes during `CALC`/`FIX` are ignored.

## Timing
- The accepting edge is edge k, where `IDLE` samples `Start` = 1.
- `Busy` is high from edge k to edge k+9.
- The eight `CALC` steps occur on edges k+1 to k+8; `FIX` occurs on edge k+9.
- `Done` rises after edge k+9: 9-cycle latency.
- Divide-by-zero: `Done` rises after edge k (1-cycle latency) and `Busy` never asserts.
- Minimum turnaround: `DONE`, then `Start` low for 1 cycle, then `IDLE`, then the next acceptance. That is 2 cycles after `Done` if `Start` is released immediately.
- Reset mid-operation: asynchronous clear to `IDLE` with all outputs at 0. No partial result is retained.
- `Busy` and `Done` are never high together.

## Structure
- Package `divider_pkg`:
  - `DIV_W` = 8.
  - State enum `div_state_t` {`IDLE`, `CALC`, `FIX`, `DONE`}.
  - Constant `DIV_ITER` = `DIV_W`.
- Sub-module `divider_control`: the FSM and 3-bit iteration counter. It outputs `load`, `step`, `fix`, `Busy` and `Done`, in the same style as the multiplier's control unit.
- The datapath (magnitude conversion, R/Q shift registers, 9-bit subtractor, sign fix-up) lives in `signed_divider`.

## Test plan
- 100 / 7 (0x64 / 0x07): `Quotient` = 0x0E, `Remainder` = 0x02, `Done` 9 cycles after acceptance, flags 0.
- -100 / 7 (0x9C / 0x07): `Quotient` = 0xF2 (-14), `Remainder` = 0xFE (-2). Also 5 / -20 (0x05 / 0xEC): `Quotient` = 0x00, `Remainder` = 0x05.
- -128 / -1 (0x80 / 0xFF): `Quotient` = 0x80, `Remainder` = 0x00, `Ovf` = 1. Also -128 / 1: `Quotient` = 0x80, `Ovf` = 0.
- 0x35 / 0x00: `DivZero` = 1, `Quotient` = 0xFF, `Remainder` = 0x35, `Done` 1 cycle after acceptance, `Busy` never high.
- Hold `Start` for 30 cycles with 0x64 / 0x07: exactly one operation and `Done` stays high. Change the operands during `DONE`: outputs unchanged until `Start` is released and re-asserted.
- Assert `Reset` low during the 4th `CALC` cycle: all outputs are 0 immediately and the state is `IDLE`. A fresh `Start` after release gives the correct result.
